fp_div: RTL and testbench

//  Multi-cycle IEEE-754 single-precision divider (FP3 = FP1 / FP2); the inverse of the FP multiplier.

---
 rtl/fp_pkg.sv | 41 ++++
 rtl/fp_mant_divider.sv | 66 ++++++
 rtl/fp_div.sv | 242 ++++++++++++++++++++++++
 tb/tb_fp_div.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants, state encoding and field helpers for the single-precision
// floating-point datapath (multiplier / divider).
package fp_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;
  localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned DIV_N = MAN_W + 3;
  localparam int unsigned CNT_W = $clog2(DIV_N);

  // Working exponent is two bits wider than the field and signed, so
  // E1 - E2 + BIAS and the normalise/round adjustments never wrap.
  localparam logic signed [EXP_W+1:0] EXP_S_BIAS = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] EXP_S_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_S_ONE  = (EXP_W+2)'(1);

  localparam logic [FP_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [FP_W-1:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    DIVIDE,
    NORM,
    PACK
  } fp_div_state_t;

  function automatic logic fp_sign(input logic [FP_W-1:0] f);
    return f[FP_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] f);
    return f[FP_W-2 -: EXP_W];
  endfunction

  function automatic logic [MAN_W-1:0] fp_man(input logic [FP_W-1:0] f);
    return f[MAN_W-1:0];
  endfunction

endpackage

// File: rtl/fp_mant_divider.sv
// Radix-2 restoring mantissa divider: one quotient bit per step, DIV_N steps.
// load_i primes rem with the dividend and captures the divisor; finished_o is
// high while the last step is being taken.
module fp_mant_divider
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [MAN_W:0]   m1_i,
  input  logic [MAN_W:0]   m2_i,
  output logic [DIV_N-1:0] q_o,
  output logic             rem_nz_o,
  output logic             finished_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_N - 1);

  // rem < 2*divisor always holds, so one bit above the mantissa suffices
  logic [MAN_W+1:0] rem_q, rem_d, diff;
  logic [MAN_W:0]   div_q, div_d;
  logic [DIV_N-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rem_ge;

  // Iteration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      div_q <= div_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

  // Load or one compare/subtract/shift step
  always_comb begin
    rem_d  = rem_q;
    div_d  = div_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    diff   = rem_q - {1'b0, div_q};
    rem_ge = (rem_q >= {1'b0, div_q});
    if (load_i) begin
      rem_d = {1'b0, m1_i};
      div_d = m2_i;
      quo_d = '0;
      cnt_d = '0;
    end else if (step_i) begin
      quo_d = {quo_q[DIV_N-2:0], rem_ge};
      rem_d = (rem_ge ? diff : rem_q) << 1;
      if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
    end
  end

  assign q_o        = quo_q;
  assign rem_nz_o   = |rem_q;
  assign finished_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/fp_div.sv
// Multi-cycle IEEE-754 single-precision divider, FP3 = FP1 / FP2.
// FSM: IDLE -> UNPACK -> DIVIDE(xDIV_N) -> NORM -> PACK -> IDLE.
// Build option FPDIV_ROUND_NEAREST_EN: round-to-nearest-even; otherwise truncate.
module fp_div
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [FP_W-1:0] FP1,
  input  logic [FP_W-1:0] FP2,
  output logic            busy,
  output logic            done,
  output logic [FP_W-1:0] FP3,
  output logic            div_by_zero,
  output logic            invalid,
  output logic            overflow
);

  fp_div_state_t state_q, state_d;
  logic [FP_W-1:0]         op1_q, op1_d, op2_q, op2_d;
  logic                    sign_q, sign_d;
  logic signed [EXP_W+1:0] exp_q, exp_d, exp_rnd;
  logic                    special_q, special_d;
  logic [FP_W-1:0]         spec_res_q, spec_res_d;
  logic                    spec_inv_q, spec_inv_d, spec_dz_q, spec_dz_d;
  logic [MAN_W-1:0]        mant_q, mant_d, mant_rnd;
  logic [FP_W-1:0]         fp3_q, fp3_d;
  logic                    done_q, done_d, dz_q, dz_d, inv_q, inv_d, ovf_q, ovf_d;
`ifdef FPDIV_ROUND_NEAREST_EN
  logic                    g_q, g_d, s_q, s_d, rnd_carry;
`endif

  logic [EXP_W-1:0] e1, e2;
  logic [MAN_W-1:0] m1, m2;
  logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, res_sign;
  logic             sp_hit, sp_inv, sp_dz;
  logic [FP_W-1:0]  sp_res;
  logic             div_load, div_step, div_fin, rem_nz;
  logic [DIV_N-1:0] quo;

  fp_mant_divider u_mant_div (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (div_load),
    .step_i     (div_step),
    .m1_i       ({1'b1, m1}),
    .m2_i       ({1'b1, m2}),
    .q_o        (quo),
    .rem_nz_o   (rem_nz),
    .finished_o (div_fin)
  );

  // State and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op1_q      <= '0;
      op2_q      <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      spec_inv_q <= 1'b0;
      spec_dz_q  <= 1'b0;
      mant_q     <= '0;
      fp3_q      <= '0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
      inv_q      <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef FPDIV_ROUND_NEAREST_EN
      g_q        <= 1'b0;
      s_q        <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      spec_inv_q <= spec_inv_d;
      spec_dz_q  <= spec_dz_d;
      mant_q     <= mant_d;
      fp3_q      <= fp3_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
      inv_q      <= inv_d;
      ovf_q      <= ovf_d;
`ifdef FPDIV_ROUND_NEAREST_EN
      g_q        <= g_d;
      s_q        <= s_d;
`endif
    end
  end

  // Operand classification and special-case result (denormals read as zero)
  always_comb begin
    e1       = fp_exp(op1_q);
    e2       = fp_exp(op2_q);
    m1       = fp_man(op1_q);
    m2       = fp_man(op2_q);
    res_sign = fp_sign(op1_q) ^ fp_sign(op2_q);
    a_zero   = (e1 == '0);
    b_zero   = (e2 == '0);
    a_inf    = (e1 == '1) && (m1 == '0);
    b_inf    = (e2 == '1) && (m2 == '0);
    a_nan    = (e1 == '1) && (m1 != '0);
    b_nan    = (e2 == '1) && (m2 != '0);
    sp_hit   = 1'b1;
    sp_res   = '0;
    sp_inv   = 1'b0;
    sp_dz    = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_res = QNAN;
      sp_inv = 1'b1;
    end else if (b_zero) begin
      sp_res = {res_sign, POS_INF[FP_W-2:0]};
      sp_dz  = !a_inf;
    end else if (a_inf) begin
      sp_res = {res_sign, POS_INF[FP_W-2:0]};
    end else if (a_zero || b_inf) begin
      sp_res = {res_sign, {(FP_W-1){1'b0}}};
    end else begin
      sp_hit = 1'b0;
    end
  end

  // Rounding of the normalised mantissa
  always_comb begin
`ifdef FPDIV_ROUND_NEAREST_EN
    {rnd_carry, mant_rnd} = {1'b0, mant_q} + (MAN_W+1)'(g_q & (s_q | mant_q[0]));
    exp_rnd = exp_q + {{(EXP_W+1){1'b0}}, rnd_carry};
`else
    mant_rnd = mant_q;
    exp_rnd  = exp_q;
`endif
  end

`ifndef FPDIV_ROUND_NEAREST_EN
  logic trunc_unused;
  assign trunc_unused = ^{quo[0], rem_nz};
`endif

  // Next-state, datapath sequencing and output packing
  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    spec_inv_d = spec_inv_q;
    spec_dz_d  = spec_dz_q;
    mant_d     = mant_q;
    fp3_d      = fp3_q;
    done_d     = 1'b0;
    dz_d       = dz_q;
    inv_d      = inv_q;
    ovf_d      = ovf_q;
    div_load   = 1'b0;
    div_step   = 1'b0;
`ifdef FPDIV_ROUND_NEAREST_EN
    g_d        = g_q;
    s_d        = s_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op1_d   = FP1;
          op2_d   = FP2;
          dz_d    = 1'b0;
          inv_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d     = res_sign;
        exp_d      = $signed({2'b00, e1}) - $signed({2'b00, e2}) + EXP_S_BIAS;
        special_d  = sp_hit;
        spec_res_d = sp_res;
        spec_inv_d = sp_inv;
        spec_dz_d  = sp_dz;
        div_load   = 1'b1;
        // Specials skip DIVIDE only; NORM leaves their state untouched
        state_d    = sp_hit ? NORM : DIVIDE;
      end
      DIVIDE: begin
        div_step = 1'b1;
        if (div_fin) state_d = NORM;
      end
      NORM: begin
        if (!special_q) begin
          if (quo[DIV_N-1]) begin
            mant_d = quo[DIV_N-2:2];
`ifdef FPDIV_ROUND_NEAREST_EN
            g_d    = quo[1];
            s_d    = quo[0] | rem_nz;
`endif
          end else begin
            mant_d = quo[DIV_N-3:1];
            exp_d  = exp_q - EXP_S_ONE;
`ifdef FPDIV_ROUND_NEAREST_EN
            g_d    = quo[0];
            s_d    = rem_nz;
`endif
          end
        end
        state_d = PACK;
      end
      PACK: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (special_q) begin
          fp3_d = spec_res_q;
          inv_d = spec_inv_q;
          dz_d  = spec_dz_q;
        end else if (exp_rnd >= EXP_S_MAX) begin
          fp3_d = {sign_q, POS_INF[FP_W-2:0]};
          ovf_d = 1'b1;
        end else if (exp_rnd < EXP_S_ONE) begin
          fp3_d = {sign_q, {(FP_W-1){1'b0}}};
        end else begin
          fp3_d = {sign_q, exp_rnd[EXP_W-1:0], mant_rnd};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign FP3         = fp3_q;
  assign div_by_zero = dz_q;
  assign invalid     = inv_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed cases, specials, random operands
// against an arithmetic reference, handshake and mid-operation reset.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] FP1, FP2, FP3;
  logic        busy, done, div_by_zero, invalid, overflow;

  int checks = 0;
  int errors = 0;

`ifdef FPDIV_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  always #5 clk = ~clk;

  fp_div dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .FP1         (FP1),
    .FP2         (FP2),
    .busy        (busy),
    .done        (done),
    .FP3         (FP3),
    .div_by_zero (div_by_zero),
    .invalid     (invalid),
    .overflow    (overflow)
  );

  // Reference: returns {overflow, invalid, div_by_zero, result}
  function automatic logic [34:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic  sg;
    int    ea, eb, e;
    longint ma, mb, n, d, q, r, mant;
    bit    a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, s;
    sg = a[31] ^ b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    ma = longint'(a[22:0]); mb = longint'(b[22:0]);
    a_nan = (ea == 255) && (ma != 0); b_nan = (eb == 255) && (mb != 0);
    a_inf = (ea == 255) && (ma == 0); b_inf = (eb == 255) && (mb == 0);
    a_zero = (ea == 0); b_zero = (eb == 0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return {3'b010, 32'h7FC00000};
    if (b_zero) return {2'b00, !a_inf, sg, 31'h7F800000};
    if (a_inf) return {3'b000, sg, 31'h7F800000};
    if (a_zero || b_inf) return {3'b000, sg, 31'h0};
    n = (ma + 64'd8388608) * 64'd33554432;
    d = mb + 64'd8388608;
    q = n / d;
    r = n % d;
    e = ea - eb + 127;
    if (q >= 64'd33554432) begin
      mant = (q >> 2) & 64'h7FFFFF; g = q[1]; s = q[0] || (r != 0);
    end else begin
      mant = (q >> 1) & 64'h7FFFFF; g = q[0]; s = (r != 0); e = e - 1;
    end
    if (RNE && g && (s || mant[0])) begin
      mant = mant + 1;
      if (mant == 64'h800000) begin mant = 0; e = e + 1; end
    end
    if (e >= 255) return {3'b100, sg, 31'h7F800000};
    if (e <= 0) return {3'b000, sg, 31'h0};
    return {3'b000, sg, 8'(e), 23'(mant)};
  endfunction

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) || (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] rand_norm();
    logic [31:0] v;
    v = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
    return v;
  endfunction

  function automatic logic [31:0] rand_any();
    int unsigned kind, e;
    logic [31:0] v;
    kind = $urandom_range(0, 9);
    e = (kind == 0) ? 0 : (kind == 1) ? 255 : $urandom_range(1, 254);
    v = {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
    if (kind == 2) v = {v[31], 8'hFF, 23'h0};
    return v;
  endfunction

  // Issue one operation and wait (bounded) for done; lat = edges after accept, -1 on timeout
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    FP1 = a; FP2 = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
  endtask

  localparam int ND = 15;
  localparam logic [31:0] RES_1_3 = RNE ? 32'h3EAAAAAB : 32'h3EAAAAAA;
  logic [31:0] dir_a [ND] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F000000,
                              32'h00800000, 32'h7F800000, 32'h7FA00000, 32'hFF800000, 32'h00000000,
                              32'h3F800000, 32'h00000001, 32'h3F800000, 32'h7F7FFFFF, 32'h00800000};
  logic [31:0] dir_b [ND] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h3E800000,
                              32'h40000000, 32'hFF800000, 32'h3F800000, 32'h00000000, 32'hFF800000,
                              32'h7F800000, 32'h3F800000, 32'h80000001, 32'h3F800000, 32'h3F800000};
  logic [34:0] dir_e [ND] = '{{3'b000, 32'h40400000}, {3'b000, RES_1_3}, {3'b001, 32'hFF800000},
                              {3'b010, 32'h7FC00000}, {3'b100, 32'h7F800000}, {3'b000, 32'h00000000},
                              {3'b010, 32'h7FC00000}, {3'b010, 32'h7FC00000}, {3'b000, 32'hFF800000},
                              {3'b000, 32'h80000000}, {3'b000, 32'h00000000}, {3'b000, 32'h00000000},
                              {3'b001, 32'hFF800000}, {3'b000, 32'h7F7FFFFF}, {3'b000, 32'h00800000}};
  int          dir_l [ND] = '{29, 29, 3, 3, 29, 29, 3, 3, 3, 3, 3, 3, 3, 29, 29};

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; FP1 = '0; FP2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, FP3, div_by_zero, invalid, overflow} !== 37'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b FP3=%h flags=%b%b%b expected all 0",
               busy, done, FP3, div_by_zero, invalid, overflow);
    end
    reset = 1'b1;
  endtask

  task automatic test_directed();
    int lat;
    for (int i = 0; i < ND; i++) begin
      run_op(dir_a[i], dir_b[i], lat);
      checks++;
      if ({overflow, invalid, div_by_zero, FP3} !== dir_e[i]) begin
        errors++;
        $display("FAIL directed[%0d] %h/%h: got flags(ovf,inv,dz)=%b%b%b FP3=%h expected %b %h",
                 i, dir_a[i], dir_b[i], overflow, invalid, div_by_zero, FP3, dir_e[i][34:32], dir_e[i][31:0]);
      end
      checks++;
      if (lat !== dir_l[i]) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d edges expected %0d", i, lat, dir_l[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse[%0d]: done=%b one cycle later expected 0", i, done);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [34:0] ev;
    int lat, el;
    for (int i = 0; i < 40; i++) begin
      a = rand_any(); b = rand_any();
      ev = ref_div(a, b);
      el = is_special(a, b) ? 3 : 29;
      run_op(a, b, lat);
      checks++;
      if ({overflow, invalid, div_by_zero, FP3} !== ev) begin
        errors++;
        $display("FAIL random[%0d] %h/%h: got flags=%b%b%b FP3=%h expected %b %h",
                 i, a, b, overflow, invalid, div_by_zero, FP3, ev[34:32], ev[31:0]);
      end
      checks++;
      if (lat !== el) begin
        errors++;
        $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, el);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int ndone, lat;
    logic [31:0] res;
    ndone = 0; lat = -1; res = '0;
    @(negedge clk);
    FP1 = 32'h40C00000; FP2 = 32'h40000000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin lat = k; res = FP3; end
      end
      if (k == 4) begin FP1 = 32'h3F800000; FP2 = 32'h40400000; start = 1'b1; end
      if (k == 5) start = 1'b0;
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL busy_ignore_count: got %0d done pulses expected 1", ndone);
    end
    checks++;
    if (res !== 32'h40400000 || lat !== 29) begin
      errors++;
      $display("FAIL busy_ignore_result: got FP3=%h lat=%0d expected 40400000 lat=29", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [34:0] ev;
    int lat;
    a = 32'h40C00000; b = 32'h40000000;
    @(negedge clk);
    FP1 = a; FP2 = b; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ev = ref_div(a, b);
      @(posedge clk); #1 start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_accept[%0d]: busy=%b after start expected 1", i, busy);
      end
      lat = -1;
      for (int k = 1; k <= 60; k++) begin
        @(posedge clk); #1;
        if (done) begin lat = k; break; end
      end
      checks++;
      if ({overflow, invalid, div_by_zero, FP3} !== ev || lat !== 29) begin
        errors++;
        $display("FAIL b2b_result[%0d] %h/%h: got flags=%b%b%b FP3=%h lat=%0d expected %b %h lat=29",
                 i, a, b, overflow, invalid, div_by_zero, FP3, lat, ev[34:32], ev[31:0]);
      end
      if (lat < 0) break;
      if (i < 3) begin
        checks++;
        if ({busy, done} !== 2'b01) begin
          errors++;
          $display("FAIL b2b_done_cycle[%0d]: busy=%b done=%b expected busy=0 done=1", i, busy, done);
        end
        a = rand_norm(); b = rand_norm();
        FP1 = a; FP2 = b; start = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, ndone;
    run_op(32'h40C00000, 32'h40000000, lat);
    checks++;
    if (FP3 !== 32'h40400000) begin
      errors++;
      $display("FAIL reset_mid_pre: got FP3=%h expected 40400000", FP3);
    end
    @(negedge clk);
    FP1 = 32'h3F800000; FP2 = 32'h40400000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, FP3, div_by_zero, invalid, overflow} !== 37'h0) begin
      errors++;
      $display("FAIL reset_mid_clear: got busy=%b done=%b FP3=%h flags=%b%b%b expected all 0",
               busy, done, FP3, div_by_zero, invalid, overflow);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort: got %0d done pulses busy=%b expected 0 and 0", ndone, busy);
    end
    run_op(32'h3F800000, 32'h40400000, lat);
    checks++;
    if ({overflow, invalid, div_by_zero, FP3} !== {3'b000, RES_1_3} || lat !== 29) begin
      errors++;
      $display("FAIL reset_mid_next: got flags=%b%b%b FP3=%h lat=%0d expected 000 %h lat=29",
               overflow, invalid, div_by_zero, FP3, lat, RES_1_3);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
